dvfs_sequencer: RTL

DVFS_SEQUENCER -- requirements
Module: dvfs_sequencer

---
 rtl/dvfs_pkg.sv | 31 +++
 rtl/dvfs_step_timer.sv | 29 ++
 rtl/dvfs_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dvfs_pkg.sv
// Shared types for the DVFS sequencer: operating-point level, FSM states and
// error codes.
package dvfs_pkg;

    typedef logic [2:0] level_t;

    localparam level_t DEFAULT_LEVEL = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FREQ_DOWN = 3'd1,
        VOLT_SET  = 3'd2,
        VOLT_WAIT = 3'd3,
        FREQ_UP   = 3'd4,
        COMPLETE  = 3'd5,
        ERROR     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_VOLT_TIMEOUT = 2'd1,
        ERR_FREQ_TIMEOUT = 2'd2,
        ERR_VOLT_FAULT   = 2'd3
    } err_code_t;

    // States in which the step timer counts towards a timeout.
    function automatic logic is_step_state(state_t s);
        return (s == FREQ_DOWN) || (s == FREQ_UP) || (s == VOLT_WAIT);
    endfunction

endpackage

// File: rtl/dvfs_step_timer.sv
// Per-step cycle counter: cleared on step entry, counts while a step is
// waiting, and flags the cycle in which the count reaches TIMEOUT_CYCLES.
module dvfs_step_timer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expired
);

    logic [23:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 24'd0;
        end else if (start) begin
            count_q <= 24'd0;
        end else if (run) begin
            count_q <= count_q + 24'd1;
        end
    end

    // count_q holds the cycles already spent in the step, so the current
    // cycle is the TIMEOUT_CYCLES-th one when count_q == TIMEOUT_CYCLES-1.
    assign expired = run && (count_q == (TIMEOUT_CYCLES - 24'd1));

endmodule

// File: rtl/dvfs_sequencer.sv
// DVFS sequencer: orders voltage and frequency steps so that voltage is raised
// before frequency on the way up and lowered after frequency on the way down.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a new operating-point request
// FREQ_DOWN | clock generator moving down to the target, waiting for ack
// VOLT_SET  | one-cycle launch of the regulator change
// VOLT_WAIT | waiting for the regulator to report the target level
// FREQ_UP   | clock generator moving up to the target, waiting for ack
// COMPLETE  | commit the target as the applied level
// ERROR     | sticky error, left only through clear_error or reset
module dvfs_sequencer
    import dvfs_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter level_t      DEFAULT_LEVEL  = dvfs_pkg::DEFAULT_LEVEL
) (
    input  logic       clk,
    input  logic       rst,
    input  level_t     perf_level_req,
    input  logic       req_valid,
    output logic       req_ready,
    output level_t     voltage_level_req,
    output logic       voltage_enable,
    input  logic       voltage_ready,
    input  level_t     current_voltage_level,
    input  logic       voltage_fault,
    output level_t     freq_level,
    output logic       freq_req,
    input  logic       freq_ack,
    output level_t     applied_level,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code,
    input  logic       clear_error
);

    state_t    state_q, state_d;
    level_t    target_q, target_d;
    logic      up_q, up_d;
    err_code_t err_code_q, err_code_d;

    logic      req_ready_q;
    level_t    volt_level_q;
    logic      volt_en_q;
    level_t    freq_level_q;
    logic      freq_req_q;
    level_t    applied_q;
    logic      busy_q;
    logic      done_q;
    logic      error_q;

    logic      step_start;
    logic      step_run;
    logic      step_expired;

    assign step_start = (state_d != state_q);
    assign step_run   = is_step_state(state_q);

    dvfs_step_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (step_start),
        .run     (step_run),
        .expired (step_expired)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        up_d       = up_q;
        err_code_d = err_code_q;
        // A regulator fault outranks both timeout and step completion.
        if (voltage_fault && (state_q != IDLE) && (state_q != ERROR)) begin
            state_d    = ERROR;
            err_code_d = ERR_VOLT_FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        target_d = perf_level_req;
                        up_d     = (perf_level_req > applied_q);
                        if (perf_level_req == applied_q) begin
                            state_d = COMPLETE;
                        end else if (perf_level_req > applied_q) begin
                            state_d = VOLT_SET;
                        end else begin
                            state_d = FREQ_DOWN;
                        end
                    end
                end
                FREQ_DOWN: begin
                    if (step_expired) begin
                        state_d    = ERROR;
                        err_code_d = ERR_FREQ_TIMEOUT;
                    end else if (freq_ack) begin
                        state_d = VOLT_SET;
                    end
                end
                VOLT_SET: begin
                    state_d = VOLT_WAIT;
                end
                VOLT_WAIT: begin
                    // A ready left over from an earlier step is ignored until
                    // the reported level matches the target.
                    if (step_expired) begin
                        state_d    = ERROR;
                        err_code_d = ERR_VOLT_TIMEOUT;
                    end else if (voltage_ready && (current_voltage_level == target_q)) begin
                        state_d = up_q ? FREQ_UP : COMPLETE;
                    end
                end
                FREQ_UP: begin
                    if (step_expired) begin
                        state_d    = ERROR;
                        err_code_d = ERR_FREQ_TIMEOUT;
                    end else if (freq_ack) begin
                        state_d = COMPLETE;
                    end
                end
                COMPLETE: begin
                    state_d = IDLE;
                end
                ERROR: begin
                    if (clear_error) begin
                        state_d    = IDLE;
                        err_code_d = ERR_NONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            target_q     <= DEFAULT_LEVEL;
            up_q         <= 1'b0;
            err_code_q   <= ERR_NONE;
            req_ready_q  <= 1'b1;
            volt_level_q <= DEFAULT_LEVEL;
            volt_en_q    <= 1'b0;
            freq_level_q <= DEFAULT_LEVEL;
            freq_req_q   <= 1'b0;
            applied_q    <= DEFAULT_LEVEL;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            up_q        <= up_d;
            err_code_q  <= err_code_d;
            req_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE) && (state_d != ERROR);
            error_q     <= (state_d == ERROR);
            volt_en_q   <= (state_d == VOLT_SET) || (state_d == VOLT_WAIT);
            freq_req_q  <= (state_d == FREQ_DOWN) || (state_d == FREQ_UP);
            done_q      <= (state_q == COMPLETE) && (state_d == IDLE);
            if (state_d == VOLT_SET) begin
                volt_level_q <= target_d;
            end
            if ((state_d == FREQ_DOWN) || (state_d == FREQ_UP)) begin
                freq_level_q <= target_d;
            end
            if ((state_q == COMPLETE) && (state_d == IDLE)) begin
                applied_q <= target_q;
            end
        end
    end

    assign req_ready         = req_ready_q;
    assign voltage_level_req = volt_level_q;
    assign voltage_enable    = volt_en_q;
    assign freq_level        = freq_level_q;
    assign freq_req          = freq_req_q;
    assign applied_level     = applied_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign error_code        = err_code_q;

endmodule
